logic_serial_ctrl: RTL and testbench

//  Bit-serial sequencer for the 1-bit logic cell (AND/OR/NOR/XOR). Accepts a WIDTH-bit

---
 rtl/logic_serial_ctrl_pkg.sv | 15 +
 rtl/logic_bit_cell.sv | 22 ++
 rtl/logic_serial_ctrl.sv | 101 ++++++++++
 tb/tb_logic_serial_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/logic_serial_ctrl_pkg.sv
// rtl/logic_serial_ctrl_pkg.sv - shared op codes and FSM encoding for the bit-serial logic sequencer
package logic_serial_ctrl_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_NOR = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/logic_bit_cell.sv
// rtl/logic_bit_cell.sv - combinational 1-bit AND/OR/NOR/XOR cell
module logic_bit_cell
  import logic_serial_ctrl_pkg::*;
(
  output logic       out,
  input  logic       a,
  input  logic       b,
  input  logic [1:0] control
);

  always_comb begin
    out = 1'b0;
    case (control)
      OP_AND:  out = a & b;
      OP_OR:   out = a | b;
      OP_NOR:  out = ~(a | b);
      OP_XOR:  out = a ^ b;
      default: out = 1'b0;
    endcase
  end

endmodule

// File: rtl/logic_serial_ctrl.sv
// rtl/logic_serial_ctrl.sv - schedules one operand bit pair per cycle through a shared logic cell
module logic_serial_ctrl
  import logic_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       control,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             cell_y;

  logic_bit_cell u_cell (
    .out     (cell_y),
    .a       (a_sh_q[0]),
    .b       (b_sh_q[0]),
    .control (op_q)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    op_d    = op_q;
    out_d   = out_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_sh_d  = A;
          b_sh_d  = B;
          op_d    = control;
          count_d = '0;
          out_d   = '0;
          zero_d  = 1'b0;
          state_d = ST_RUN;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        out_d[count_q] = cell_y;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        // Counter parks at LAST instead of wrapping so non-power-of-2 widths stay in range.
        if (count_q == LAST) begin
          zero_d  = ~|out_d;
          state_d = ST_DONE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      op_q    <= '0;
      out_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      op_q    <= op_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign out  = out_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_logic_serial_ctrl.sv
// tb/tb_logic_serial_ctrl.sv - randomized self-checking bench for logic_serial_ctrl (WIDTH 8 and 5)
module tb_logic_serial_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start8, start5;
  logic [7:0] A, B;
  logic [1:0] control;
  logic       busy8, done8, zero8;
  logic [7:0] out8;
  logic       busy5, done5, zero5;
  logic [4:0] out5;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  logic_serial_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .A(A), .B(B), .control(control),
    .busy(busy8), .done(done8), .out(out8), .zero(zero8)
  );

  logic_serial_ctrl #(.WIDTH(5)) dut5 (
    .clk(clk), .reset(reset), .start(start5), .A(A[4:0]), .B(B[4:0]), .control(control),
    .busy(busy5), .done(done5), .out(out5), .zero(zero5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] c, input int w);
    logic [7:0] r;
    case (c)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = ~(a | b);
      default: r = a ^ b;
    endcase
    return (w == 8) ? r : (r & 8'h1F);
  endfunction

  function automatic logic cur_busy(input int w);
    return (w == 8) ? busy8 : busy5;
  endfunction
  function automatic logic cur_done(input int w);
    return (w == 8) ? done8 : done5;
  endfunction
  function automatic logic cur_zero(input int w);
    return (w == 8) ? zero8 : zero5;
  endfunction
  function automatic logic [7:0] cur_out(input int w);
    return (w == 8) ? out8 : {3'b000, out5};
  endfunction

  // hold keeps start high through RUN and DONE; chained means the caller is
  // already at the negedge of a DONE cycle and this op must start with no gap.
  task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] c, input bit hold, input bit chained);
    logic [7:0] exp;
    int bc;
    bit got;
    exp = ref_op(a, b, c, w);
    if (!chained) @(negedge clk);
    A = a; B = b; control = c;
    if (w == 8) start8 = 1'b1; else start5 = 1'b1;
    @(posedge clk);
    #1;
    if (chained) check("b2b_busy", 32'(cur_busy(w)), 32'd1);
    if (!hold) begin start8 = 1'b0; start5 = 1'b0; end
    A = 8'($urandom); B = 8'($urandom); control = 2'($urandom);
    bc = 0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cur_done(w)) begin got = 1'b1; break; end
      if (cur_busy(w)) bc++;
      A = 8'($urandom); B = 8'($urandom); control = 2'($urandom);
    end
    check("done_seen", 32'(got), 32'd1);
    check("busy_len", 32'(bc), 32'(w));
    check("out", 32'(cur_out(w)), 32'(exp));
    check("zero", 32'(cur_zero(w)), 32'(exp == 8'h00));
    if (!hold) begin
      @(negedge clk);
      check("done_1cyc", 32'(cur_done(w)), 32'd0);
      check("idle_busy", 32'(cur_busy(w)), 32'd0);
      check("out_held", 32'(cur_out(w)), 32'(exp));
    end
  endtask

  initial begin
    bit seen;
    reset = 1'b1; start8 = 1'b0; start5 = 1'b0;
    A = '0; B = '0; control = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_out", 32'(out8), 32'd0);
    check("rst_zero", 32'(zero8), 32'd0);
    check("rst_out5", 32'(out5), 32'd0);
    reset = 1'b0;

    run_op(8, 8'hF0, 8'hCC, 2'b00, 1'b0, 1'b0);
    run_op(8, 8'hF0, 8'hCC, 2'b01, 1'b0, 1'b0);
    run_op(8, 8'hF0, 8'hCC, 2'b10, 1'b0, 1'b0);
    run_op(8, 8'hF0, 8'hCC, 2'b11, 1'b0, 1'b0);
    run_op(8, 8'hAA, 8'h55, 2'b00, 1'b0, 1'b0);
    run_op(8, 8'hAA, 8'h55, 2'b01, 1'b0, 1'b0);

    run_op(8, 8'h3C, 8'hA5, 2'b11, 1'b1, 1'b0);
    run_op(8, 8'h96, 8'h0F, 2'b10, 1'b1, 1'b1);
    run_op(8, 8'hF0, 8'hCC, 2'b00, 1'b0, 1'b1);

    @(negedge clk);
    A = 8'hF0; B = 8'hCC; control = 2'b01; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy", 32'(busy8), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_out", 32'(out8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) seen = 1'b1;
    end
    check("abort_nodone", 32'(seen), 32'd0);

    @(negedge clk);
    reset = 1'b1; start8 = 1'b1;
    @(negedge clk);
    check("rst_wins", 32'(busy8), 32'd0);
    reset = 1'b0; start8 = 1'b0;

    run_op(5, 8'h1F, 8'h0A, 2'b11, 1'b0, 1'b0);
    run_op(5, 8'h15, 8'h0A, 2'b00, 1'b0, 1'b0);

    for (int k = 0; k < 16; k++) begin
      run_op(($urandom_range(0, 1) != 0) ? 8 : 5, 8'($urandom), 8'($urandom),
             2'($urandom), 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
